// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/acknowledge bus
//
// Purpose: groups the data-memory handshake between the core-side initiator
//          (mem_access_unit) and a data memory responder.
// Signals:
//   MReq   initiator -> responder  request pending
//   MWe    initiator -> responder  1 = write, 0 = read
//   MAdr   initiator -> responder  word address {2'b00, byte_addr[31:2]}
//   MBe    initiator -> responder  byte enables, lane i = bits [8i+7:8i]
//   MWdata initiator -> responder  lane-replicated write data
//   MAck   responder -> initiator  request accepted / read data valid
//   MRdata responder -> initiator  read word, valid with MAck
// Modports: master = initiator side, slave = responder side.

interface mem_access_unit_if;
  logic        MReq;
  logic        MWe;
  logic [31:0] MAdr;
  logic [3:0]  MBe;
  logic [31:0] MWdata;
  logic        MAck;
  logic [31:0] MRdata;

  modport master (
    output MReq, MWe, MAdr, MBe, MWdata,
    input  MAck, MRdata
  );

  modport slave (
    input  MReq, MWe, MAdr, MBe, MWdata,
    output MAck, MRdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS data-memory port initiator
//
// Purpose: takes one load/store per Start pulse, checks alignment, issues a
//          request/acknowledge access on the memory bus, extends load data
//          and stalls the core until the access completes or times out.
// Ports:
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   Start           core presents an instruction this cycle
//   Ins             instruction, opcode in Ins[31:26]
//   Result          effective byte address
//   Rdata2          store source data
//   Stall           core must hold its instruction (combinational)
//   LoadData        extended load result (registered)
//   LoadValid       one-cycle pulse, LoadData valid
//   Fault           one-cycle pulse: 01 misaligned, 10 timeout
//   mem             memory bus, master side
// Parameter TIMEOUT: REQ cycles without MAck before abort (1..255).

module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic [1:0]  Fault,
  mem_access_unit_if.master mem
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  op_q, op_d;       // {unsigned, size[1:0]} from opcode bits [28:26]
  logic [1:0]  lo_q, lo_d;       // byte offset within the word
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic [1:0]  fault_q, fault_d;

  logic [5:0]  op;
  logic        memop;
  logic        misal;
  logic        accept;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic        unused_ins;

  assign op         = Ins[31:26];
  assign unused_ins = ^Ins[25:0];

  // Opcode bit 3 = store, bit 2 = unsigned load, bits [1:0] = size
  // (00 byte, 01 half, 11 word).
  always_comb begin
    memop = 1'b0;
    case (op)
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: memop = 1'b1;
      default: memop = 1'b0;
    endcase
  end

  always_comb begin
    misal     = 1'b0;
    be_fmt    = 4'b1111;
    wdata_fmt = Rdata2;
    case (op[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << Result[1:0];
        wdata_fmt = {4{Rdata2[7:0]}};
      end
      2'b01: begin
        misal     = Result[0];
        be_fmt    = 4'b0011 << {Result[1], 1'b0};
        wdata_fmt = {2{Rdata2[15:0]}};
      end
      default: begin
        misal     = (Result[1:0] != 2'b00);
        be_fmt    = 4'b1111;
        wdata_fmt = Rdata2;
      end
    endcase
    if (!op[3]) wdata_fmt = 32'h0;
  end

  assign accept = Start & memop & ~misal;
  assign Stall  = (state_q == S_REQ) | ((state_q == S_IDLE) & accept);

  // Load extraction uses the latched offset and size, not the live inputs.
  always_comb begin
    case (lo_q)
      2'd0:    rd_byte = mem.MRdata[7:0];
      2'd1:    rd_byte = mem.MRdata[15:8];
      2'd2:    rd_byte = mem.MRdata[23:16];
      default: rd_byte = mem.MRdata[31:24];
    endcase
    rd_half = lo_q[1] ? mem.MRdata[31:16] : mem.MRdata[15:0];
    case (op_q[1:0])
      2'b00:   rd_ext = op_q[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = op_q[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_ext = mem.MRdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    adr_d        = adr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    lo_d         = lo_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (Start && memop) begin
          if (misal) begin
            fault_d = 2'b01;
          end else begin
            state_d = S_REQ;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            we_d    = op[3];
            adr_d   = {2'b00, Result[31:2]};
            be_d    = be_fmt;
            wdata_d = wdata_fmt;
            op_d    = op[2:0];
            lo_d    = Result[1:0];
          end
        end
      end
      default: begin
        // Bus outputs return to zero once the access ends, matching reset.
        if (mem.MAck) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          adr_d   = 32'h0;
          be_d    = 4'h0;
          wdata_d = 32'h0;
          if (!we_q) begin
            load_data_d  = rd_ext;
            load_valid_d = 1'b1;
          end
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th REQ cycle without an ack.
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          adr_d   = 32'h0;
          be_d    = 4'h0;
          wdata_d = 32'h0;
          fault_d = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 32'h0;
      be_q         <= 4'h0;
      wdata_q      <= 32'h0;
      op_q         <= 3'h0;
      lo_q         <= 2'h0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
      fault_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
      lo_q         <= lo_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign mem.MReq   = req_q;
  assign mem.MWe    = we_q;
  assign mem.MAdr   = adr_q;
  assign mem.MBe    = be_q;
  assign mem.MWdata = wdata_q;
  assign LoadData   = load_data_q;
  assign LoadValid  = load_valid_q;
  assign Fault      = fault_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the data-memory port for the MIPS core. Accepts one load/store per `Start` pulse from the execute stage, checks alignment, and drives a request/acknowledge handshake toward a data memory responder with word address, byte enables and lane-replicated write data. It extracts and sign/zero-extends load data, and stalls the core until the access completes or times out.

## Interface

Parameters:
- `TIMEOUT`, default 15: cycles `MReq` may stay high without `MAck` before abort; legal range 1–255.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous reset, active-high.
- `Start` in 1: core presents an instruction this cycle.
- `Ins` in 32: instruction; opcode is `Ins[31:26]`.
- `Result` in 32: ALU effective byte address.
- `Rdata2` in 32: store source register.
- `Stall` out 1: core must hold its current instruction.
- `LoadData` out 32: extended load result, registered.
- `LoadValid` out 1: one-cycle pulse marking a valid `LoadData`.
- `Fault` out 2: one-cycle pulse. `01` = misaligned, `10` = timeout, `00` = none.
- `MReq` out 1: request to memory.
- `MWe` out 1: 1 = write.
- `MAdr` out 32: word address, `{2'b00, addr[31:2]}`.
- `MBe` out 4: byte enables. Lane i = bits `[8i+7:8i]`, little-endian.
- `MWdata` out 32: write data.
- `MAck` in 1: responder accepted or returned data this cycle.
- `MRdata` in 32: read word, valid when `MAck`=1.

## Operation

- **Memory opcodes:** LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- **Other opcodes:** `Start` with any other opcode is ignored; no state change.
- **Alignment:** halfword ops are misaligned if `addr[0]`=1. Word ops are misaligned if `addr[1:0]`≠0. Byte ops never fault.
- **Lane formatting:**
  - SB: `MBe = 4'b0001 << addr[1:0]`, `MWdata = {4{Rdata2[7:0]}}`.
  - SH: `MBe = 4'b0011 << {addr[1],1'b0}`, `MWdata = {2{Rdata2[15:0]}}`.
  - SW: `MBe = 4'b1111`, `MWdata = Rdata2`.
  - Loads drive the same `MBe` patterns; `MWdata` = 0.
- **Load extraction:** select the byte or halfword from `MRdata` by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- **FSM states:** IDLE, REQ.
  - IDLE, `Start` & memory op & aligned: latch `MAdr`, `MBe`, `MWdata`, `MWe`, opcode and `addr[1:0]`; clear the wait counter; go to REQ.
  - IDLE, `Start` & memory op & misaligned: `Fault`=01 next cycle; stay in IDLE; no request issued.
  - REQ: `MReq`=1. All M* outputs are held stable until the state is left.
  - REQ & `MAck`: go to IDLE. For a load, `LoadData` ← extracted value and `LoadValid`=1 next cycle. For a store, `LoadValid` stays 0.
  - REQ & !`MAck`: counter +1. When the counter reaches `TIMEOUT`, go to IDLE, `Fault`=10 next cycle, `LoadData` unchanged.
- **Stall:** `Stall = (state==REQ) | (state==IDLE & Start & memop & aligned)`. This is combinational, so the core stalls in the `Start` cycle.
- **Ignored inputs:** `MAck` in IDLE; `Start` in REQ.

## Timing

- **Reset values:** all outputs 0 (`MReq`, `MWe`, `MAdr`, `MBe`, `MWdata`, `LoadData`, `LoadValid`, `Fault`, `Stall`). State = IDLE, counter = 0.
- **Reset mid-access:** `RST` in REQ drops `MReq` at that edge. No `LoadValid` or `Fault` is produced for the aborted access.
- **Zero-wait access:** `Start` in cycle T → `MReq` high in T+1 → `MAck` in T+1 → `LoadValid` in T+2. `Stall` is high in T and T+1 and low in T+2.
- **Wait states:** each cycle without `MAck` adds one cycle of `MReq` and `Stall`.
- **Timeout:** `MReq` high for exactly `TIMEOUT` cycles with no ack → `MReq` low and `Fault`=10 in the next cycle.
- **Ack on the last timeout cycle:** `MAck` arriving in the cycle the counter reaches `TIMEOUT` takes priority; the access completes normally.
- **Back-to-back issue:** `Start` is accepted in the same cycle `LoadValid` or `Fault` pulses. Peak rate is one access per 2 cycles.
- **Pulse width:** `LoadValid` and `Fault` are exactly one cycle wide.

## Test plan

- **LW:** `Result`=0x0000_0010, responder acks in the first REQ cycle with `MRdata`=0xDEAD_BEEF → `MAdr`=0x4, `MBe`=1111, `MWe`=0; `LoadData`=0xDEAD_BEEF with `LoadValid` at T+2.
- **Byte loads:** `addr`=0x13, `MRdata`=0x80FF_0000. LB → `MBe`=1000, `LoadData`=0xFFFF_FF80. LBU → `LoadData`=0x0000_0080.
- **SH with wait states:** `addr`=0x6, `Rdata2`=0x1234_ABCD, ack after 3 wait cycles → `MBe`=1100, `MWdata`=0xABCD_ABCD, `MWe`=1, `MReq` high 4 cycles, `Stall` high 5 cycles, no `LoadValid`.
- **Misaligned:** LW at 0x2 and LH at 0x1 → `Fault`=01 one cycle, `MReq` never asserts, `Stall` stays 0.
- **Timeout:** `TIMEOUT`=4, no ack → `MReq` high 4 cycles, then `Fault`=10. A following LW at 0x8 with immediate ack completes normally.
- **Reset mid-access:** `RST` pulsed in the second REQ cycle → `MReq` and `Stall` low after that edge, all outputs 0. A subsequent SB completes normally.
